// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone SDRAM stand-in responder.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Widest byte-select vector the mask helper handles.
    localparam int SEL_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BURST
    } wb_rsp_state_t;

    function automatic logic [8*SEL_MAX-1:0] sel_to_mask(
        input logic [SEL_MAX-1:0] sel
    );
        logic [8*SEL_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < SEL_MAX; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_rsp_mem.sv
// Word array with byte-masked write and a registered read port.
module wb_rsp_mem #(
    parameter int DW   = 32,
    parameter int AW_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic            re_i,
    input  logic            clr_i,
    input  logic [AW_W-1:0] addr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW-1:0]   wmask_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [2**AW_W];
    logic [DW-1:0] rdata_q;

    // Array contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~wmask_i)
                           | (wdata_i & wmask_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sdram_responder.sv
// Wishbone B4 responder backed by a local array, standing in for SDRAM.
module wb_sdram_responder
    import wb_pkg::*;
#(
    parameter int dw          = 32,
    parameter int AW          = 26,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic [dw/8-1:0] wb_sel_i,
    input  logic [2:0]      wb_cti_i,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [15:0]     wr_cnt_o,
    output logic [15:0]     rd_cnt_o
);

    localparam int NB = dw / 8;
    localparam int L  = $clog2(NB);

    wb_rsp_state_t         state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  oor_q, oor_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [15:0]           wr_cnt_q, rd_cnt_q;

    logic                  req;
    logic                  oor;
    logic [DEPTH_LOG2-1:0] idx;
    logic [8*SEL_MAX-1:0]  mask_full;
    logic                  unused_bits;
    logic                  mem_we, mem_re, dat_clr;
    logic                  wr_inc, rd_inc;

    assign req       = wb_cyc_i & wb_stb_i;
    assign idx       = wb_addr_i[L+DEPTH_LOG2-1:L];
    assign oor       = |wb_addr_i[AW-1:L+DEPTH_LOG2];
    assign mask_full = sel_to_mask(SEL_MAX'(wb_sel_i));
    assign unused_bits = ^{mask_full, wb_addr_i[L-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        oor_d   = oor_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        dat_clr = 1'b0;
        wr_inc  = 1'b0;
        rd_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = idx;
                    oor_d  = oor;
                    we_d   = wb_we_i;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (oor_q) begin
                    err_d   = 1'b1;
                    dat_clr = 1'b1;
                end else begin
                    ack_d  = 1'b1;
                    mem_we = we_q;
                    wr_inc = we_q;
                    mem_re = !we_q;
                    rd_inc = !we_q;
                    if (wb_cti_i == CTI_INCR && req) begin
                        state_d = ST_BURST;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (req) begin
                    ack_d  = 1'b1;
                    mem_we = we_q;
                    wr_inc = we_q;
                    mem_re = !we_q;
                    rd_inc = !we_q;
                    addr_d = addr_q + 1'b1;
                    if (wb_cti_i != CTI_INCR) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (wr_inc) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (rd_inc) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    wb_rsp_mem #(
        .DW   (dw),
        .AW_W (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (sys_clk),
        .rst_ni  (RESETN),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .clr_i   (dat_clr),
        .addr_i  (addr_q),
        .wdata_i (wb_dat_i),
        .wmask_i (mask_full[dw-1:0]),
        .rdata_o (wb_dat_o)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;

endmodule
